inst_fetch_bridge: RTL and testbench

INST_FETCH_BRIDGE -- requirements
Module: inst_fetch_bridge

---
 rtl/inst_fetch_bridge.sv | 113 +++++++++++
 tb/tb_inst_fetch_bridge.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: one-entry line buffer in front of a gnt/rvalid memory bus,
// with a bounded wait that substitutes NOP_INST and pulses fetch_err_o on timeout.
module inst_fetch_bridge #(
    parameter logic [7:0]  TIMEOUT  = 8'd255,
    parameter logic [31:0] NOP_INST = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    output logic [31:0] rom_data_o,
    output logic        stallreq_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        fetch_err_o,
    output logic [1:0]  dbg_state
);

    // Bus handshake: mem_req_o/mem_addr_o stay stable in REQ until mem_gnt_i is seen;
    // mem_rvalid_i is honoured only in REQ (same-cycle) or WAIT, never in IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        buf_valid;
    logic [29:0] buf_addr;
    logic [31:0] buf_data;
    logic [29:0] req_addr;
    logic [7:0]  wait_cnt;
    logic        hit;
    logic        miss;
    logic        fill;
    logic        timeout;
    logic [31:0] fill_data;

    assign hit        = rom_ce_i & buf_valid & (rom_addr_i[31:2] == buf_addr);
    assign miss       = rom_ce_i & ~hit;
    // Reset forces every combinational output low regardless of inputs.
    assign rom_data_o = (rst & hit) ? buf_data : 32'h0;
    assign stallreq_o = rst & miss;
    assign mem_req_o  = rst & (state == REQ);
    assign mem_addr_o = mem_req_o ? {req_addr, 2'b00} : 32'h0;
    assign dbg_state  = state;

    always_comb begin
        state_next = state;
        fill       = 1'b0;
        timeout    = 1'b0;
        fill_data  = mem_rdata_i;
        case (state)
            IDLE: begin
                if (miss) state_next = REQ;
            end
            REQ: begin
                if (mem_gnt_i) begin
                    if (mem_rvalid_i) begin
                        fill       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                // rvalid wins over a coinciding timeout.
                if (mem_rvalid_i) begin
                    fill       = 1'b1;
                    state_next = IDLE;
                end else if (({1'b0, wait_cnt} + 9'd1) >= {1'b0, TIMEOUT}) begin
                    fill       = 1'b1;
                    timeout    = 1'b1;
                    fill_data  = NOP_INST;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            buf_valid   <= 1'b0;
            buf_addr    <= 30'h0;
            buf_data    <= 32'h0;
            req_addr    <= 30'h0;
            wait_cnt    <= 8'h0;
            fetch_err_o <= 1'b0;
        end else begin
            state       <= state_next;
            fetch_err_o <= timeout;
            if (state == IDLE && miss) req_addr <= rom_addr_i[31:2];
            if (state == REQ) begin
                wait_cnt <= 8'h0;
            end else if (state == WAIT && !mem_rvalid_i) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (fill) begin
                buf_valid <= 1'b1;
                buf_addr  <= req_addr;
                buf_data  <= fill_data;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Bench for inst_fetch_bridge: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the line buffer and pending fetch.
module tb_inst_fetch_bridge;

    localparam logic [31:0] NOP = 32'h00000000;
    localparam int          TMO = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rom_ce_i = 1'b0;
    logic [31:0] rom_addr_i = 32'h0;
    logic [31:0] rom_data_o;
    logic        stallreq_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        fetch_err_o;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    int grants = 0;

    inst_fetch_bridge dut (
        .clk(clk), .rst(rst), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i),
        .rom_data_o(rom_data_o), .stallreq_o(stallreq_o), .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .fetch_err_o(fetch_err_o), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: the buffered word plus at most one outstanding fetch.
    logic        m_valid = 1'b0;
    logic [29:0] m_word  = 30'h0;
    logic [31:0] m_data  = 32'h0;
    logic        m_pend  = 1'b0;
    logic        m_granted = 1'b0;
    int          m_waited = 0;
    logic [29:0] m_target = 30'h0;
    logic        m_err   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the model, then advance model and DUT by one clock.
    task automatic step();
        logic        hit;
        logic        req;
        logic [31:0] exp_data;
        #1;
        hit      = rst && rom_ce_i && m_valid && (rom_addr_i[31:2] == m_word);
        req      = rst && m_pend && !m_granted;
        exp_data = hit ? m_data : 32'h0;
        check("rom_data", rom_data_o, exp_data);
        check("stall", {31'h0, stallreq_o}, {31'h0, rst && rom_ce_i && !hit});
        check("mem_req", {31'h0, mem_req_o}, {31'h0, req});
        check("mem_addr", mem_addr_o, req ? {m_target, 2'b00} : 32'h0);
        check("fetch_err", {31'h0, fetch_err_o}, {31'h0, m_err});
        if (mem_req_o && mem_gnt_i) grants++;
        if (!rst) begin
            m_valid = 1'b0; m_word = '0; m_data = '0; m_pend = 1'b0;
            m_granted = 1'b0; m_waited = 0; m_target = '0; m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (!m_pend) begin
                if (rom_ce_i && !hit) begin
                    m_pend = 1'b1; m_granted = 1'b0; m_target = rom_addr_i[31:2];
                end
            end else if (!m_granted) begin
                if (mem_gnt_i && mem_rvalid_i) begin
                    m_valid = 1'b1; m_word = m_target; m_data = mem_rdata_i; m_pend = 1'b0;
                end else if (mem_gnt_i) begin
                    m_granted = 1'b1; m_waited = 0;
                end
            end else if (mem_rvalid_i) begin
                m_valid = 1'b1; m_word = m_target; m_data = mem_rdata_i; m_pend = 1'b0;
            end else begin
                m_waited++;
                if (m_waited >= TMO) begin
                    m_valid = 1'b1; m_word = m_target; m_data = NOP; m_pend = 1'b0; m_err = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ce, input logic [31:0] addr, input logic gnt,
                         input logic rv, input logic [31:0] rd);
        rom_ce_i = ce; rom_addr_i = addr; mem_gnt_i = gnt; mem_rvalid_i = rv; mem_rdata_i = rd;
    endtask

    initial begin
        int g0;
        // Reset with noisy inputs: outputs must stay quiet.
        rst = 1'b0;
        drive(1'b1, 32'h40, 1'b1, 1'b1, 32'h12345678);
        step(); step(); step();
        rst = 1'b1;

        // Basic miss: gnt at N+1, rvalid at N+2, hit at N+3.
        drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        step();
        drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h34011100);
        step();
        drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check("miss_latency_data", rom_data_o, 32'h34011100);
        check("miss_latency_stall", {31'h0, stallreq_o}, 32'h0);
        step();

        // Same-cycle gnt+rvalid, then 0x6 shares the word fetched for 0x4.
        g0 = grants;
        drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b1, 32'h4, 1'b1, 1'b1, 32'hDEADBEEF);
        step();
        drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
        #1;
        check("fast_fill_hit", rom_data_o, 32'hDEADBEEF);
        step();
        drive(1'b1, 32'h6, 1'b1, 1'b1, 32'h0BADF00D);
        #1;
        check("same_word_data", rom_data_o, 32'hDEADBEEF);
        step();
        check("single_request", grants - g0, 32'd1);

        // Address moves 0x8 -> 0xC during WAIT: 0x8 fill completes first.
        drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h0);
        step();
        drive(1'b1, 32'hC, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b1, 32'hC, 1'b0, 1'b1, 32'hAAAA0008);
        step();
        drive(1'b1, 32'hC, 1'b0, 1'b0, 32'h0);
        step();
        #1;
        check("refetch_addr", mem_addr_o, 32'hC);
        check("refetch_req", {31'h0, mem_req_o}, 32'h1);
        drive(1'b1, 32'hC, 1'b1, 1'b1, 32'hBBBB000C);
        step();
        drive(1'b1, 32'hC, 1'b0, 1'b0, 32'h0);
        #1;
        check("refetch_data", rom_data_o, 32'hBBBB000C);
        step();

        // Timeout: 255 WAIT cycles without rvalid.
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h0);
        step();
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < TMO; i++) step();
        #1;
        check("timeout_err", {31'h0, fetch_err_o}, 32'h1);
        check("timeout_data", rom_data_o, NOP);
        check("timeout_stall", {31'h0, stallreq_o}, 32'h0);
        step();
        check("timeout_err_pulse", {31'h0, fetch_err_o}, 32'h0);

        // Reset during WAIT, late rvalid ignored, fresh miss issued.
        drive(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        drive(1'b0, 32'h200, 1'b0, 1'b1, 32'h55555555);
        step();
        drive(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
        #1;
        check("post_reset_stall", {31'h0, stallreq_o}, 32'h1);
        check("post_reset_data", rom_data_o, 32'h0);
        step();
        #1;
        check("post_reset_req", mem_addr_o, 32'h200);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            rst = (($urandom_range(0, 80)) != 0);
            drive(($urandom_range(0, 3)) != 0,
                  32'($urandom_range(0, 5) * 4 + $urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2)) == 0,
                  $urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
